// File: rtl/game_txt_rom_arbiter.sv
// Round-robin arbiter sharing one registered text ROM between N_REQ renderers.
// One lookup per clock, optional per-requester burst lock with a cap, and
// responses tagged one-hot to the requester one clock after its grant.
module game_txt_rom_arbiter #(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = 8,
  parameter int CODE_W    = 7,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [CODE_W-1:0]       rsp_code,
  output logic [ADDR_W-1:0]       rom_char_xy,
  input  logic [CODE_W-1:0]       rom_char_code,
  output logic                    busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              owner_valid_q, owner_valid_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0] last_xy_q, last_xy_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  cand;
  logic              gnt_any;
  logic              lock_win;

  // Unpack per-requester addresses and decode the winning index into one-hot grants.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
    assign gnt[gi]      = gnt_any & (gnt_idx == IDX_W'(gi));
  end

  // Pick the winner: a locked owner under its burst cap, else round-robin from ptr.
  // Arbitration is suppressed while reset is asserted so no grant escapes.
  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = '0;
    lock_win = 1'b0;
    if (rst_n) begin
      lock_win = owner_valid_q & req[owner_q] & lock[owner_q] & (burst_cnt_q < MAX_CNT);
      if (lock_win) begin
        gnt_idx = owner_q;
        gnt_any = 1'b1;
      end else begin
        for (int j = 0; j < N_REQ; j++) begin
          cand = IDX_W'((int'(ptr_q) + j) % N_REQ);
          if (!gnt_any && req[cand]) begin
            gnt_idx = cand;
            gnt_any = 1'b1;
          end
        end
      end
    end
  end

  // Next-state: grant bookkeeping; an owner that drops req or lock loses ownership.
  always_comb begin
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q & req[owner_q] & lock[owner_q];
    burst_cnt_d   = burst_cnt_q;
    last_xy_d     = last_xy_q;
    rsp_valid_d   = gnt;
    if (gnt_any) begin
      last_xy_d     = addr_arr[gnt_idx];
      ptr_d         = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      burst_cnt_d   = lock_win ? burst_cnt_q + 1'b1 : CNT_W'(1);
      owner_d       = gnt_idx;
      owner_valid_d = lock[gnt_idx];
    end
  end

  // State registers; reset also kills any response already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      last_xy_q     <= '0;
      rsp_valid_q   <= '0;
    end else begin
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      last_xy_q     <= last_xy_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

  assign rom_char_xy = gnt_any ? addr_arr[gnt_idx] : last_xy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_code    = rom_char_code;
  assign busy        = |rsp_valid_q;

endmodule
